// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - zero-fill initialiser and two-port round-robin arbiter for a single-port ram
module ram_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int N_WORDS    = 32,
    parameter int ADDR_WIDTH = $clog2(N_WORDS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  init_done,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_address,
    input  logic [DATA_WIDTH-1:0] req0_data,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_address,
    input  logic [DATA_WIDTH-1:0] req1_data,

    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_data,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_data,

    output logic                  ram_we,
    output logic                  ram_re,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    input  logic [DATA_WIDTH-1:0] ram_data_out
);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N_WORDS - 1);

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic                  fill_issued;
    logic                  prio;

    logic                  grant0;
    logic                  grant1;
    logic                  accept;
    logic                  win_id;
    logic                  win_we;
    logic [ADDR_WIDTH-1:0] win_address;
    logic [DATA_WIDTH-1:0] win_data;

    logic                  rd_s1;
    logic                  rd_s2;
    logic                  id_s1;
    logic                  id_s2;

    // prio names the requester that wins a tie
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == ST_RUN) begin
            if (req0_valid && req1_valid) begin
                grant0 = !prio;
                grant1 = prio;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign accept     = grant0 | grant1;
    assign win_id     = grant1;

    always_comb begin
        if (grant1) begin
            win_we      = req1_we;
            win_address = req1_address;
            win_data    = req1_data;
        end else begin
            win_we      = req0_we;
            win_address = req0_address;
            win_data    = req0_data;
        end
    end

    // fill_issued marks the cycle after the last zero-write, before RUN is entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_INIT;
            init_cnt    <= '0;
            fill_issued <= 1'b0;
            init_done   <= 1'b0;
            prio        <= 1'b0;
            ram_we      <= 1'b0;
            ram_re      <= 1'b0;
            ram_address <= '0;
            ram_data_in <= '0;
        end else if (state == ST_INIT) begin
            ram_re <= 1'b0;
            if (!fill_issued) begin
                ram_we      <= 1'b1;
                ram_address <= init_cnt;
                ram_data_in <= '0;
                if (init_cnt == LAST_ADDR) begin
                    fill_issued <= 1'b1;
                end else begin
                    init_cnt <= init_cnt + 1'b1;
                end
            end else begin
                ram_we    <= 1'b0;
                state     <= ST_RUN;
                init_done <= 1'b1;
            end
        end else begin
            ram_we <= accept && win_we;
            ram_re <= accept && !win_we;
            if (accept) begin
                ram_address <= win_address;
                ram_data_in <= win_data;
                prio        <= !win_id;
            end
        end
    end

    // two-stage tag pipeline lines the response up with the ram's read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_s1      <= 1'b0;
            id_s1      <= 1'b0;
            rd_s2      <= 1'b0;
            id_s2      <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
        end else begin
            rd_s1      <= accept && !win_we;
            id_s1      <= win_id;
            rd_s2      <= rd_s1;
            id_s2      <= id_s1;
            rsp0_valid <= rd_s2 && !id_s2;
            rsp1_valid <= rd_s2 && id_s2;
        end
    end

    assign rsp0_data = ram_data_out;
    assign rsp1_data = ram_data_out;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - randomized and directed bench for ram_arbiter against a memory-level model
module tb_ram_arbiter;
    localparam int DW = 16;
    localparam int NW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          init_done;
    logic          req0_valid, req0_ready, req0_we;
    logic [AW-1:0] req0_address;
    logic [DW-1:0] req0_data;
    logic          req1_valid, req1_ready, req1_we;
    logic [AW-1:0] req1_address;
    logic [DW-1:0] req1_data;
    logic          rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp0_data, rsp1_data;
    logic          ram_we, ram_re;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data_in, ram_data_out;

    ram_arbiter #(.DATA_WIDTH(DW), .N_WORDS(NW)) dut (
        .clk(clk), .rst_n(rst_n), .init_done(init_done),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_address(req0_address), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_address(req1_address), .req1_data(req1_data),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
        .ram_we(ram_we), .ram_re(ram_re), .ram_address(ram_address),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
    );

    always #5 clk = ~clk;

    // attached ram: samples a read on one edge, presents it on the next; starts full of junk
    logic [DW-1:0] mem [NW];
    logic [DW-1:0] rd_q;
    bit            seeded = 1'b0;
    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < NW; i++) mem[i] <= DW'($urandom);
            seeded <= 1'b1;
        end else if (ram_we) begin
            mem[ram_address] <= ram_data_in;
        end
        if (ram_re) rd_q <= mem[ram_address];
        ram_data_out <= rd_q;
    end

    int cyc = 0;
    int since_rel = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        since_rel <= rst_n ? since_rel + 1 : 0;
    end

    typedef struct {
        int            cyc;
        logic [DW-1:0] data;
    } rsp_t;

    int            total = 0;
    int            bad = 0;
    rsp_t          q0[$];
    rsp_t          q1[$];
    logic [DW-1:0] ref_mem [NW];
    bit            mptr;
    int            rsp_cnt0 = 0;
    int            rsp_cnt1 = 0;
    logic [DW-1:0] last0, last1;

    // one clock of traffic: drive, check readies against the model, then check responses
    task automatic step(input bit v0, input bit we0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input bit v1, input bit we1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        output bit acc0, output bit acc1);
        bit   run, g0, g1, e0, e1;
        rsp_t e;
        req0_valid = v0; req0_we = we0; req0_address = a0; req0_data = d0;
        req1_valid = v1; req1_we = we1; req1_address = a1; req1_data = d1;
        #1;
        run = (since_rel >= NW + 1);
        g0  = run && v0 && (!v1 || !mptr);
        g1  = run && v1 && (!v0 || mptr);
        total++;
        if (req0_ready !== g0 || req1_ready !== g1) begin
            bad++;
            $display("FAIL ready cyc=%0d got=%b%b expected=%b%b", cyc, req0_ready, req1_ready, g0, g1);
        end
        acc0 = v0 && (req0_ready === 1'b1);
        acc1 = v1 && (req1_ready === 1'b1);
        if (g0) begin
            if (we0) ref_mem[a0] = d0;
            else begin e.cyc = cyc + 3; e.data = ref_mem[a0]; q0.push_back(e); end
            mptr = 1'b1;
        end else if (g1) begin
            if (we1) ref_mem[a1] = d1;
            else begin e.cyc = cyc + 3; e.data = ref_mem[a1]; q1.push_back(e); end
            mptr = 1'b0;
        end
        @(negedge clk);
        e0 = (q0.size() > 0) && (q0[0].cyc == cyc);
        e1 = (q1.size() > 0) && (q1[0].cyc == cyc);
        total += 2;
        if (rsp0_valid !== e0) begin
            bad++;
            $display("FAIL rsp0_valid cyc=%0d got=%b expected=%b", cyc, rsp0_valid, e0);
        end
        if (rsp1_valid !== e1) begin
            bad++;
            $display("FAIL rsp1_valid cyc=%0d got=%b expected=%b", cyc, rsp1_valid, e1);
        end
        if (e0) begin
            total++;
            if (rsp0_data !== q0[0].data) begin
                bad++;
                $display("FAIL rsp0_data cyc=%0d got=%h expected=%h", cyc, rsp0_data, q0[0].data);
            end
        end
        if (e1) begin
            total++;
            if (rsp1_data !== q1[0].data) begin
                bad++;
                $display("FAIL rsp1_data cyc=%0d got=%h expected=%h", cyc, rsp1_data, q1[0].data);
            end
        end
        if (rsp0_valid === 1'b1) begin rsp_cnt0++; last0 = rsp0_data; end
        if (rsp1_valid === 1'b1) begin rsp_cnt1++; last1 = rsp1_data; end
        while (q0.size() > 0 && q0[0].cyc <= cyc) void'(q0.pop_front());
        while (q1.size() > 0 && q1[0].cyc <= cyc) void'(q1.pop_front());
    endtask

    task automatic idle(input int n);
        bit x0, x1;
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0, '0, '0, x0, x1);
    endtask

    // asserts reset now; returns at the falling edge right after release
    task automatic do_reset();
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        mptr = 1'b0;
        for (int i = 0; i < NW; i++) ref_mem[i] = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        req0_valid = 1'b1; req0_we = 1'b0; req0_address = '0; req0_data = '0;
        req1_valid = 1'b1; req1_we = 1'b0; req1_address = '0; req1_data = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({init_done, ram_we, ram_re, rsp0_valid, rsp1_valid, req0_ready, req1_ready} !== 7'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b expected=0000000",
                     {init_done, ram_we, ram_re, rsp0_valid, rsp1_valid, req0_ready, req1_ready});
        end
        total++;
        if (ram_address !== '0 || ram_data_in !== '0) begin
            bad++;
            $display("FAIL reset_bus got addr=%h data=%h expected 0/0", ram_address, ram_data_in);
        end
    endtask

    task automatic test_init();
        int  c0;
        bit  x0, x1;
        do_reset();
        for (int e = 1; e <= NW + 1; e++) begin
            @(negedge clk);
            #1;
            total++;
            if (e <= NW) begin
                if ({ram_we, ram_re, init_done, req0_ready, req1_ready} !== 5'b10000 ||
                    ram_address !== AW'(e - 1) || ram_data_in !== '0) begin
                    bad++;
                    $display("FAIL init_fill edge=%0d got we=%b re=%b done=%b rdy=%b%b addr=%0d data=%h expected 1 0 0 00 %0d 0",
                             e, ram_we, ram_re, init_done, req0_ready, req1_ready, ram_address, ram_data_in, e - 1);
                end
            end else begin
                if ({ram_we, init_done, req0_ready, req1_ready} !== 4'b0110) begin
                    bad++;
                    $display("FAIL init_end got we=%b done=%b rdy=%b%b expected 0 1 10",
                             ram_we, init_done, req0_ready, req1_ready);
                end
            end
        end
        c0 = rsp_cnt0;
        for (int a = 0; a < NW; a++) step(1, 0, AW'(a), '0, 0, 0, '0, '0, x0, x1);
        idle(3);
        total++;
        if (rsp_cnt0 !== c0 + NW) begin
            bad++;
            $display("FAIL init_readback count got=%0d expected=%0d", rsp_cnt0 - c0, NW);
        end
    endtask

    task automatic test_single();
        int c0, c1;
        bit x0, x1;
        c0 = rsp_cnt0; c1 = rsp_cnt1;
        step(1, 1, 5'd5, 16'hBEEF, 0, 0, '0, '0, x0, x1);
        step(1, 0, 5'd5, '0, 0, 0, '0, '0, x0, x1);
        idle(3);
        total++;
        if (rsp_cnt0 !== c0 + 1 || rsp_cnt1 !== c1 || last0 !== 16'hBEEF) begin
            bad++;
            $display("FAIL single got cnt0=+%0d cnt1=+%0d data=%h expected +1 +0 beef",
                     rsp_cnt0 - c0, rsp_cnt1 - c1, last0);
        end
    endtask

    task automatic test_contention();
        int            n0, n1, c0, c1;
        bit            acc0, acc1, prev;
        logic [AW-1:0] a0, a1;
        n0 = 0; n1 = 0; prev = 1'b0;
        c0 = rsp_cnt0; c1 = rsp_cnt1;
        a0 = AW'($urandom); a1 = AW'($urandom);
        for (int i = 0; i < 8; i++) begin
            step(1, 0, a0, '0, 1, 0, a1, '0, acc0, acc1);
            total++;
            if (acc0 == acc1 || (i > 0 && acc1 == prev)) begin
                bad++;
                $display("FAIL alternate i=%0d got acc=%b%b prev_winner=%0d", i, acc0, acc1, prev);
            end
            prev = acc1;
            if (acc0) begin n0++; a0 = AW'($urandom); end
            if (acc1) begin n1++; a1 = AW'($urandom); end
        end
        idle(3);
        total++;
        if (n0 != 4 || n1 != 4 || rsp_cnt0 - c0 != 4 || rsp_cnt1 - c1 != 4) begin
            bad++;
            $display("FAIL fairness got acc=%0d/%0d rsp=%0d/%0d expected 4/4 4/4",
                     n0, n1, rsp_cnt0 - c0, rsp_cnt1 - c1);
        end
    endtask

    task automatic test_pointer();
        bit acc0, acc1;
        step(0, 0, '0, '0, 1, 1, 5'd3, 16'h1111, acc0, acc1);
        step(1, 0, 5'd3, '0, 1, 0, 5'd4, '0, acc0, acc1);
        total++;
        if (!acc0 || acc1) begin
            bad++;
            $display("FAIL ptr_after_req1 got acc=%b%b expected=10", acc0, acc1);
        end
        step(1, 1, 5'd6, 16'h2222, 0, 0, '0, '0, acc0, acc1);
        idle(1);
        step(1, 0, 5'd6, '0, 1, 0, 5'd3, '0, acc0, acc1);
        total++;
        if (acc0 || !acc1) begin
            bad++;
            $display("FAIL ptr_after_idle got acc=%b%b expected=01", acc0, acc1);
        end
        idle(3);
    endtask

    task automatic test_back_to_back();
        int c0;
        bit x0, x1;
        c0 = rsp_cnt0;
        step(0, 0, '0, '0, 1, 1, 5'd31, 16'h1234, x0, x1);
        step(1, 0, 5'd31, '0, 0, 0, '0, '0, x0, x1);
        idle(3);
        total++;
        if (rsp_cnt0 !== c0 + 1 || last0 !== 16'h1234) begin
            bad++;
            $display("FAIL b2b got cnt=+%0d data=%h expected +1 1234", rsp_cnt0 - c0, last0);
        end
    endtask

    task automatic test_reset_mid_read();
        int c0, c1;
        bit x0, x1;
        step(1, 1, 5'd5, 16'hBEEF, 0, 0, '0, '0, x0, x1);
        step(1, 0, 5'd5, '0, 0, 0, '0, '0, x0, x1);
        c0 = rsp_cnt0; c1 = rsp_cnt1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({init_done, ram_re, ram_we, rsp0_valid, rsp1_valid} !== 5'b0) begin
            bad++;
            $display("FAIL midreset got done=%b re=%b we=%b rsp=%b%b expected all 0",
                     init_done, ram_re, ram_we, rsp0_valid, rsp1_valid);
        end
        do_reset();
        idle(NW + 2);
        total++;
        if (rsp_cnt0 !== c0 || rsp_cnt1 !== c1 || init_done !== 1'b1) begin
            bad++;
            $display("FAIL dropped_read got cnt=+%0d/+%0d done=%b expected +0/+0 1",
                     rsp_cnt0 - c0, rsp_cnt1 - c1, init_done);
        end
        step(1, 0, 5'd5, '0, 0, 0, '0, '0, x0, x1);
        idle(3);
        total++;
        if (rsp_cnt0 !== c0 + 1 || last0 !== 16'h0000) begin
            bad++;
            $display("FAIL reinit_clear got cnt=+%0d data=%h expected +1 0000", rsp_cnt0 - c0, last0);
        end
    endtask

    task automatic test_random();
        bit            pv [2];
        bit            pwe [2];
        logic [AW-1:0] pa [2];
        logic [DW-1:0] pd [2];
        bit            acc0, acc1;
        pv[0] = 0; pv[1] = 0;
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pv[p] && $urandom_range(0, 9) < 6) begin
                    pv[p]  = 1'b1;
                    pwe[p] = 1'($urandom);
                    pa[p]  = AW'($urandom_range(0, 7));
                    pd[p]  = DW'($urandom);
                end
            end
            step(pv[0], pwe[0], pa[0], pd[0], pv[1], pwe[1], pa[1], pd[1], acc0, acc1);
            if (acc0) pv[0] = 1'b0;
            if (acc1) pv[1] = 1'b0;
        end
        idle(4);
        total++;
        if (q0.size() != 0 || q1.size() != 0) begin
            bad++;
            $display("FAIL random_drain got pending=%0d/%0d expected 0/0", q0.size(), q1.size());
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_single();
        test_contention();
        test_pointer();
        test_back_to_back();
        test_reset_mid_read();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
